// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity sense and default frame geometry.
// Used by both the receive and transmit paths.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_PRESCALE   = 8;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter with a three-point majority vote around mid-bit.
// Raises sample_done on the last oversample tick of each bit.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic rx,
   output logic sample_done,
   output logic sample_bit
);

   localparam int EW = $clog2(PRESCALE);
   localparam logic [EW-1:0] LAST   = EW'(PRESCALE - 1);
   localparam logic [EW-1:0] MID_LO = EW'(PRESCALE / 2 - 1);
   localparam logic [EW-1:0] MID    = EW'(PRESCALE / 2);
   localparam logic [EW-1:0] MID_HI = EW'(PRESCALE / 2 + 1);

   logic [EW-1:0] edge_cnt_q, edge_cnt_d;
   logic          s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
   logic          s2;

   always_comb begin
      edge_cnt_d = '0;
      s0_d       = s0_q;
      s1_d       = s1_q;
      s2_d       = s2_q;
      if (run) begin
         edge_cnt_d = (edge_cnt_q == LAST) ? '0 : edge_cnt_q + 1'b1;
         if (edge_cnt_q == MID_LO) s0_d = rx;
         if (edge_cnt_q == MID)    s1_d = rx;
         if (edge_cnt_q == MID_HI) s2_d = rx;
      end
      // At PRESCALE=4 the third sample point coincides with the decision tick
      s2          = (edge_cnt_q == MID_HI) ? rx : s2_q;
      sample_done = run && (edge_cnt_q == LAST);
      sample_bit  = majority3(s0_q, s1_q, s2);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         edge_cnt_q <= '0;
         s0_q       <= 1'b1;
         s1_q       <= 1'b1;
         s2_q       <= 1'b1;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         s0_q       <= s0_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start qualification, LSB-first deserialise, optional parity, stop check.
// Define UART_RX_IN_SYNC_EN to insert a 2-flop synchroniser on RX_IN (+2 cycles latency).
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge while armed
// START  | confirming the start bit at mid-bit
// DATA   | shifting in DATA_WIDTH payload bits
// PARITY | checking the parity bit against the payload
// STOP   | checking the stop bit, issuing the result strobe
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int PRESCALE   = DEF_PRESCALE
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  DATA_VLD,
   output logic                  PAR_ERR,
   output logic                  STP_ERR
);

   localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

   logic rx;

`ifdef UART_RX_IN_SYNC_EN
   logic rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;

   always_comb begin
      rx_meta_d = RX_IN;
      rx_sync_d = rx_meta_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_meta_d;
         rx_sync_q <= rx_sync_d;
      end
   end

   assign rx = rx_sync_q;
`else
   assign rx = RX_IN;
`endif

   uart_state_e           state_q, state_d;
   logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
   logic                  par_mis_q, par_mis_d;
   logic                  armed_q, armed_d;
   logic                  data_vld_q, data_vld_d, par_err_q, par_err_d, stp_err_q, stp_err_d;
   logic                  start_det, run, sample_done, sample_bit;

   assign start_det = (state_q == IDLE) && armed_q && !rx;
   assign run       = (state_q != IDLE) || start_det;

   uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
      .clk         (CLK),
      .rst         (RST),
      .run         (run),
      .rx          (rx),
      .sample_done (sample_done),
      .sample_bit  (sample_bit)
   );

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      p_data_d   = p_data_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      par_mis_d  = par_mis_q;
      // Arming only on a seen-high line keeps us off a frame already in flight
      armed_d    = armed_q | ((state_q == IDLE) && rx);
      data_vld_d = 1'b0;
      par_err_d  = 1'b0;
      stp_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_det) begin
               state_d   = START;
               bit_cnt_d = '0;
               par_en_d  = PAR_EN;
               par_typ_d = PAR_TYP;
               par_mis_d = 1'b0;
            end
         end
         START: begin
            if (sample_done) state_d = sample_bit ? IDLE : DATA;
         end
         DATA: begin
            if (sample_done) begin
               shift_d[bit_cnt_q] = sample_bit;
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = par_en_q ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (sample_done) begin
               par_mis_d = sample_bit != ((^shift_q) ^ (par_typ_q == PAR_ODD));
               state_d   = STOP;
            end
         end
         STOP: begin
            if (sample_done) begin
               stp_err_d = !sample_bit;
               par_err_d = par_mis_q;
               if (sample_bit && !par_mis_q) begin
                  p_data_d   = shift_q;
                  data_vld_d = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         p_data_q   <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         par_mis_q  <= 1'b0;
         armed_q    <= 1'b0;
         data_vld_q <= 1'b0;
         par_err_q  <= 1'b0;
         stp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         p_data_q   <= p_data_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         par_mis_q  <= par_mis_d;
         armed_q    <= armed_d;
         data_vld_q <= data_vld_d;
         par_err_q  <= par_err_d;
         stp_err_q  <= stp_err_d;
      end
   end

   assign P_DATA   = p_data_q;
   assign DATA_VLD = data_vld_q;
   assign PAR_ERR  = par_err_q;
   assign STP_ERR  = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at PRESCALE=8, DATA_WIDTH=8.
// Cycle 0 of each run is the cycle whose RX_IN value is the first wave entry.
module tb_uart_rx;

   localparam int P  = 8;
   localparam int DW = 8;

   logic          CLK = 1'b0;
   logic          RST, RX_IN, PAR_EN, PAR_TYP;
   logic [DW-1:0] P_DATA;
   logic          DATA_VLD, PAR_ERR, STP_ERR;

   int            n_checks = 0;
   int            n_errors = 0;

   bit            wave[$];
   int            vld_cyc[$];
   logic [7:0]    vld_dat[$];
   int            perr_cyc[$];
   int            serr_cyc[$];
   logic [7:0]    pdata_post_rst;
   logic [2:0]    strb_post_rst;

   uart_rx #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .RX_IN    (RX_IN),
      .PAR_EN   (PAR_EN),
      .PAR_TYP  (PAR_TYP),
      .P_DATA   (P_DATA),
      .DATA_VLD (DATA_VLD),
      .PAR_ERR  (PAR_ERR),
      .STP_ERR  (STP_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int first_of(input int q[$]);
      return (q.size() > 0) ? q[0] : -1;
   endfunction

   task automatic add_level(input bit v, input int n);
      repeat (n) wave.push_back(v);
   endtask

   task automatic add_frame(input logic [7:0] d, input bit has_par, input bit par_bit,
                            input bit stop_bit);
      add_level(1'b0, P);
      for (int i = 0; i < DW; i++) add_level(d[i], P);
      if (has_par) add_level(par_bit, P);
      add_level(stop_bit, P);
   endtask

   // Plays the wave one entry per cycle; outputs are sampled on the falling edge.
   task automatic run_wave(input int extra, input int rst_cyc, input int flip_cyc);
      int n;
      vld_cyc.delete();
      vld_dat.delete();
      perr_cyc.delete();
      serr_cyc.delete();
      n = wave.size() + extra;
      for (int c = 0; c < n; c++) begin
         @(negedge CLK);
         if (DATA_VLD) begin
            vld_cyc.push_back(c);
            vld_dat.push_back(P_DATA);
         end
         if (PAR_ERR) perr_cyc.push_back(c);
         if (STP_ERR) serr_cyc.push_back(c);
         if (c == rst_cyc + 1) begin
            pdata_post_rst = P_DATA;
            strb_post_rst  = {DATA_VLD, PAR_ERR, STP_ERR};
         end
         RX_IN = (c < wave.size()) ? wave[c] : 1'b1;
         RST   = (c == rst_cyc);
         if (c == flip_cyc) PAR_EN = ~PAR_EN;
      end
      wave.delete();
   endtask

   task automatic chk_frame(input string tag, input int e_vld, input int e_perr, input int e_serr,
                            input logic [7:0] e_data);
      int e_n;
      e_n = ((e_vld >= 0) ? 1 : 0) + ((e_perr >= 0) ? 1 : 0) + ((e_serr >= 0) ? 1 : 0);
      check({tag, "/n_strobes"}, vld_cyc.size() + perr_cyc.size() + serr_cyc.size(), e_n);
      check({tag, "/vld_cyc"}, first_of(vld_cyc), e_vld);
      check({tag, "/perr_cyc"}, first_of(perr_cyc), e_perr);
      check({tag, "/serr_cyc"}, first_of(serr_cyc), e_serr);
      check({tag, "/p_data"}, P_DATA, e_data);
   endtask

   initial begin
      int idx;
      RST     = 1'b1;
      RX_IN   = 1'b1;
      PAR_EN  = 1'b0;
      PAR_TYP = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst/p_data", P_DATA, 8'h00);
      check("rst/strobes", {DATA_VLD, PAR_ERR, STP_ERR}, 3'b000);
      RST = 1'b0;
      run_wave(4, -1, -1);

      // Plain frame, no parity
      add_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      run_wave(6, -1, -1);
      chk_frame("a5", 80, -1, -1, 8'hA5);

      // One-cycle glitch at a data-bit sample point, walking the three points
      for (int i = 0; i < DW; i++) begin
         add_frame(8'hA5, 1'b0, 1'b0, 1'b1);
         idx       = (1 + i) * P + 3 + (i % 3);
         wave[idx] = ~wave[idx];
         run_wave(6, -1, -1);
         chk_frame($sformatf("a5_glitch%0d", i), 80, -1, -1, 8'hA5);
      end

      // Even parity: 0x3C has four ones -> parity bit 0
      PAR_EN  = 1'b1;
      PAR_TYP = 1'b0;
      add_frame(8'h3C, 1'b1, 1'b0, 1'b1);
      run_wave(6, -1, -1);
      chk_frame("3c_par_ok", 88, -1, -1, 8'h3C);
      add_frame(8'h3C, 1'b1, 1'b1, 1'b1);
      run_wave(6, -1, -1);
      chk_frame("3c_par_bad", -1, 88, -1, 8'h3C);

      // Odd parity: 0x07 has three ones -> parity bit 0; PAR_EN dropped mid-frame is ignored
      PAR_TYP = 1'b1;
      add_frame(8'h07, 1'b1, 1'b0, 1'b1);
      run_wave(6, -1, 20);
      chk_frame("07_odd_latch", 88, -1, -1, 8'h07);

      // Stop-bit errors
      PAR_EN  = 1'b0;
      PAR_TYP = 1'b0;
      add_frame(8'h81, 1'b0, 1'b0, 1'b0);
      run_wave(6, -1, -1);
      chk_frame("81_stop0", -1, -1, 80, 8'h07);
      PAR_EN = 1'b1;
      add_frame(8'h81, 1'b1, 1'b1, 1'b0);
      run_wave(6, -1, -1);
      chk_frame("81_par_stop", -1, 88, 88, 8'h07);

      // Short low pulse in IDLE, then a frame starting at cycle 8
      PAR_EN = 1'b0;
      add_level(1'b0, 2);
      add_level(1'b1, 6);
      add_frame(8'hC3, 1'b0, 1'b0, 1'b1);
      run_wave(6, -1, -1);
      chk_frame("false_start", 88, -1, -1, 8'hC3);

      // Back-to-back frames with no idle gap
      add_frame(8'h01, 1'b0, 1'b0, 1'b1);
      add_frame(8'hFF, 1'b0, 1'b0, 1'b1);
      run_wave(6, -1, -1);
      check("b2b/n_vld", vld_cyc.size(), 2);
      check("b2b/cyc0", (vld_cyc.size() > 0) ? vld_cyc[0] : -1, 80);
      check("b2b/dat0", (vld_dat.size() > 0) ? vld_dat[0] : 8'hxx, 8'h01);
      check("b2b/cyc1", (vld_cyc.size() > 1) ? vld_cyc[1] : -1, 160);
      check("b2b/dat1", (vld_dat.size() > 1) ? vld_dat[1] : 8'hxx, 8'hFF);
      check("b2b/errs", perr_cyc.size() + serr_cyc.size(), 0);

      // Reset during data bit 4, line held low, one high cycle, then a new frame
      add_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      while (wave.size() > 43) void'(wave.pop_back());
      add_level(1'b0, 100);
      add_level(1'b1, 1);
      add_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      run_wave(6, 42, -1);
      check("rst_mid/p_data", pdata_post_rst, 8'h00);
      check("rst_mid/strobes", strb_post_rst, 3'b000);
      chk_frame("rst_mid", 224, -1, -1, 8'h5A);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
